lsu_result_fifo: RTL and testbench
==================================

// Module: lsu_result_fifo
// PURPOSE
//  Buffers LSU completion packets (cdb_info_t) produced by the LSU issue queue after the DCache response.
//  Decouples the cache pipeline from CDB arbitration: lsu_iq pushes via entry_valid/fifo_ready.
//  The CDB arbiter pops in order. Gives the LSU pipe its back-pressure point. Squashed on flush.
// PARAMETERS
//  DEPTH    4                   number of result slots; power of two, >= 2
//  PTR_LEN  $clog2(DEPTH)       read/write pointer width (derived)
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         asynchronous active-low reset
//  flush          in   1         synchronous pipeline flush; empties buffer
//  entry_valid_i  in   1         lsu_iq result valid (lsu_iq.entry_valid_o)
//  fifo_ready_o   out  1         buffer can accept this cycle (to lsu_iq.fifo_ready)
//  result_i       in   cdb_info_t  completion packet (lsu_iq.result_o)
//  cdb_valid_o    out  1         head entry valid toward CDB arbiter
//  cdb_ready_i    in   1         arbiter accepts head this cycle
//  cdb_o          out  cdb_info_t  head entry
//  count_o        out  PTR_LEN+1 current occupancy (perf/debug)
// BEHAVIOUR
//  - Clock: single clock clk. Reset: rst_n asynchronous, active-low. Both are fixed.
//  - Reset (async): rd_ptr=wr_ptr=0, count=0 -> fifo_ready_o=1, cdb_valid_o=0, count_o=0, cdb_o='0.
//  - flush (sync, highest priority): same state as reset next cycle; push/pop in that cycle are discarded.
//  - push = entry_valid_i & fifo_ready_o; pop = cdb_valid_o & cdb_ready_i.
//  - fifo_ready_o = (count != DEPTH) | cdb_ready_i.
//    This is a pop-through-full path: when full, a same-cycle pop frees the slot.
//  - cdb_valid_o = (count != 0). cdb_o = mem[rd_ptr] when valid, else '0.
//  - No combinational bypass: a packet pushed in cycle N is visible on cdb_o no earlier than N+1.
//  - Ordering: strict FIFO, with no reordering of loads relative to stores.
//  - The single_load/single_store/lsu_info fields pass through untouched.
//  - Pointers are PTR_LEN bits and wrap naturally from DEPTH-1 to 0. count is PTR_LEN+1 bits.
//  - Update rules: push only -> count+1; pop only -> count-1; push & pop -> count unchanged, both pointers advance.
//  - Simultaneous push & pop when empty: illegal by construction, since pop requires count != 0.
//    The push is taken and count becomes 1.
//  - Simultaneous push & pop when full: both are taken and count stays at DEPTH.
//    The head is read before the write lands, because the write goes to wr_ptr == rd_ptr only after rd_ptr advances.
//    The storage write uses the pre-update wr_ptr, which equals rd_ptr while full.
//    The read data is taken combinationally from the old contents; the write is registered. Result is correct.
//  - result_i with r_valid==0 (bubble/invalid inst) is still stored and forwarded. ROB/CDB qualifies on r_valid.
//  - cdb_o and cdb_valid_o must stay stable while cdb_valid_o & ~cdb_ready_i (valid/ready hold rule).
//  - Reset mid-operation: all entries are lost immediately and the outputs drop asynchronously.
//  - Storage is a flop array (mem[DEPTH]) and is not reset. Only the pointers and count are reset.
//    cdb_o is masked to '0 while empty.
// STRUCTURE
//  - cdb_info_t and lsu_iq_pkg_t stay in the shared defines package. No new typedefs.
//  - This block adds no shared constants. DEPTH is local.
//  - Single flat module, no sub-module. Pointer/count logic is one always_ff with async reset.
//  - Storage is one always_ff without reset, written on push.
// TESTING
//  - Reset/idle: assert rst_n=0 mid-cycle -> cdb_valid_o=0, fifo_ready_o=1, count_o=0 immediately.
//  - Fill: push 4 packets (rob_id 1..4), cdb_ready_i=0 -> count_o=4, fifo_ready_o=0, cdb_o.rob_id=1.
//    A 5th entry_valid_i is not accepted.
//  - Drain order: from full, cdb_ready_i=1 for 4 cycles -> cdb_o.rob_id 1,2,3,4 on consecutive cycles.
//    cdb_valid_o then drops.
//  - Full pass-through: full, push rob_id 5 with cdb_ready_i=1 -> rob_id 1 is popped and 5 is accepted.
//    count_o stays 4; subsequent order is 2,3,4,5.
//  - Wrap-around: 10 push/pop pairs with random ready gaps -> FIFO order is preserved across the pointer wrap.
//    count_o never exceeds 4. Scoreboard matches.
//  - Flush: 3 entries held, flush=1 with push (rob_id 9) and pop in the same cycle.
//    Next cycle count_o=0, cdb_valid_o=0, and rob_id 9 never appears.

Source files
------------

// File: rtl/lsu_result_fifo_pkg.sv
// Shared LSU completion packet type consumed by the result buffer and the CDB arbiter.
package lsu_result_fifo_pkg;

  typedef struct packed {
    logic        r_valid;
    logic [5:0]  rob_id;
    logic [31:0] data;
    logic        single_load;
    logic        single_store;
    logic [3:0]  lsu_info;
  } cdb_info_t;

endpackage

// File: rtl/lsu_result_fifo.sv
// In-order LSU result buffer between lsu_iq and the CDB arbiter; push visible on cdb_o one cycle later.
// Back-pressure via fifo_ready_o, which stays high when full if the head pops in the same cycle.
module lsu_result_fifo
  import lsu_result_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   entry_valid_i,
  output logic                   fifo_ready_o,
  input  cdb_info_t              result_i,
  output logic                   cdb_valid_o,
  input  logic                   cdb_ready_i,
  output cdb_info_t              cdb_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_LEN = $clog2(DEPTH);
  localparam logic [PTR_LEN:0]   FULL_CNT = (PTR_LEN + 1)'(DEPTH);
  localparam logic [PTR_LEN:0]   CNT_ONE  = (PTR_LEN + 1)'(1);
  localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

  logic [PTR_LEN-1:0] r_rd_ptr;
  logic [PTR_LEN-1:0] r_wr_ptr;
  logic [PTR_LEN:0]   r_count;
  cdb_info_t          r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign cdb_valid_o  = (r_count != '0);
  assign fifo_ready_o = (r_count != FULL_CNT) | cdb_ready_i;
  assign w_push       = entry_valid_i & fifo_ready_o;
  assign w_pop        = cdb_valid_o & cdb_ready_i;
  assign count_o      = r_count;
  // Head is read from the old contents, so a full-state push into rd_ptr's slot is safe.
  assign cdb_o        = cdb_valid_o ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= result_i;
  end

endmodule

// File: tb/tb_lsu_result_fifo.sv
// Scoreboard bench for lsu_result_fifo: a queue model predicts every output each cycle.
module tb_lsu_result_fifo;
  import lsu_result_fifo_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      flush;
  logic      entry_valid_i;
  logic      fifo_ready_o;
  cdb_info_t result_i;
  logic      cdb_valid_o;
  logic      cdb_ready_i;
  cdb_info_t cdb_o;
  logic [2:0] count_o;

  lsu_result_fifo #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .entry_valid_i(entry_valid_i),
    .fifo_ready_o (fifo_ready_o),
    .result_i     (result_i),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_ready_i  (cdb_ready_i),
    .cdb_o        (cdb_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  cdb_info_t sb_q[$];
  int popped_ids[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic cdb_info_t mk(input logic [5:0] id);
    cdb_info_t p;
    p.r_valid      = id[0];
    p.rob_id       = id;
    p.data         = 32'hA500_0000 | (32'(id) * 32'd3);
    p.single_load  = id[1];
    p.single_store = id[2];
    p.lsu_info     = id[3:0] ^ 4'h5;
    return p;
  endfunction

  // Drive one cycle of inputs, check outputs at the falling edge, then advance the model.
  task automatic step(input logic ev, input logic [5:0] id, input logic rdy, input logic fl,
                      output logic accepted);
    logic m_valid, m_ready, m_push, m_pop;
    cdb_info_t m_head;
    entry_valid_i = ev;
    result_i      = mk(id);
    cdb_ready_i   = rdy;
    flush         = fl;
    @(negedge clk);
    m_valid = (sb_q.size() != 0);
    m_ready = (sb_q.size() != 4) || rdy;
    m_head  = m_valid ? sb_q[0] : '0;
    chk("count",  64'(count_o), 64'(sb_q.size()));
    chk("valid",  64'(cdb_valid_o), 64'(m_valid));
    chk("ready",  64'(fifo_ready_o), 64'(m_ready));
    chk("cdb_o",  64'(cdb_o), 64'(m_head));
    m_push = ev && m_ready;
    m_pop  = m_valid && rdy;
    accepted = m_push && !fl;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (m_pop) popped_ids.push_back(int'(sb_q.pop_front().rob_id));
      if (m_push) sb_q.push_back(mk(id));
    end
    @(posedge clk);
    #1;
  endtask

  logic acc;
  int   next_id;
  int   pushed;
  int   cyc;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    entry_valid_i = 1'b0;
    cdb_ready_i = 1'b0;
    result_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset
    step(1'b0, 6'd0, 1'b0, 1'b0, acc);

    // Fill with 1..4, then a 5th offer must be refused
    for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b0, 1'b0, acc);
    step(1'b1, 6'd5, 1'b0, 1'b0, acc);
    chk("fifth_refused", 64'(acc), 64'(0));
    chk("head_after_fill", 64'(cdb_o.rob_id), 64'(1));

    // Drain in order
    popped_ids.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    chk("drain_n", 64'(popped_ids.size()), 64'(4));
    for (int i = 0; i < popped_ids.size(); i++) chk("drain_order", 64'(popped_ids[i]), 64'(i + 1));

    // Full pass-through: pop 1 and push 5 in the same cycle
    for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b0, 1'b0, acc);
    popped_ids.delete();
    step(1'b1, 6'd5, 1'b1, 1'b0, acc);
    chk("pass_accept", 64'(acc), 64'(1));
    step(1'b0, 6'd0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    chk("pass_n", 64'(popped_ids.size()), 64'(5));
    for (int i = 0; i < popped_ids.size(); i++) chk("pass_order", 64'(popped_ids[i]), 64'(i + 1));

    // Wrap-around with random ready gaps
    popped_ids.delete();
    next_id = 10;
    pushed  = 0;
    cyc     = 0;
    while ((pushed < 10 || sb_q.size() != 0) && cyc < 200) begin
      step(pushed < 10 && ($urandom_range(0, 3) != 0), 6'(next_id),
           1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) begin
        next_id++;
        pushed++;
      end
      if (count_o > 3'd4) chk("count_le4", 64'(count_o), 64'(4));
      cyc++;
    end
    chk("wrap_done", 64'(pushed == 10 && sb_q.size() == 0), 64'(1));
    chk("wrap_n", 64'(popped_ids.size()), 64'(10));
    for (int i = 0; i < popped_ids.size(); i++) chk("wrap_order", 64'(popped_ids[i]), 64'(10 + i));

    // Flush with concurrent push (9) and pop
    for (int i = 1; i <= 3; i++) step(1'b1, 6'(20 + i), 1'b0, 1'b0, acc);
    step(1'b1, 6'd9, 1'b1, 1'b1, acc);
    step(1'b0, 6'd0, 1'b0, 1'b0, acc);
    chk("flush_count", 64'(count_o), 64'(0));
    popped_ids.delete();
    step(1'b1, 6'd30, 1'b0, 1'b0, acc);
    step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    chk("post_flush_n", 64'(popped_ids.size()), 64'(1));
    if (popped_ids.size() > 0) chk("post_flush_id", 64'(popped_ids[0]), 64'(30));

    // Asynchronous reset mid-cycle with entries held
    step(1'b1, 6'd40, 1'b0, 1'b0, acc);
    step(1'b1, 6'd41, 1'b0, 1'b0, acc);
    entry_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(cdb_valid_o), 64'(0));
    chk("arst_ready", 64'(fifo_ready_o), 64'(1));
    chk("arst_count", 64'(count_o), 64'(0));
    chk("arst_cdb_o", 64'(cdb_o), 64'(0));
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 6'd50, 1'b0, 1'b0, acc);
    step(1'b0, 6'd0, 1'b1, 1'b0, acc);
    step(1'b0, 6'd0, 1'b0, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
